// File: rtl/bot_viewport_scroller.sv
// Viewport scroller: maps display-relative video coordinates onto the world map
// around the Rojobot, with offsets changing only at frame boundaries.
module bot_viewport_scroller #(
  parameter int MAP_W    = 8,
  parameter int VIEW_W   = 6,
  parameter int ADDR_W   = 11,
  parameter int MAX_STEP = 4,
  parameter int MARGIN   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [MAP_W-1:0]  LocX,
  input  logic [MAP_W-1:0]  LocY,
  input  logic              loc_valid,
  input  logic              frame_sync,
  input  logic [1:0]        scroll_mode,
  input  logic [ADDR_W-1:0] vid_row,
  input  logic [ADDR_W-1:0] vid_col,
  output logic [ADDR_W-1:0] map_row,
  output logic [ADDR_W-1:0] map_col,
  output logic              in_view,
  output logic [MAP_W-1:0]  off_x,
  output logic [MAP_W-1:0]  off_y,
  output logic              busy
);

  localparam int SW   = MAP_W + 2;
  localparam int V    = 1 << VIEW_W;
  localparam int OMAX = (1 << MAP_W) - V;

  localparam logic signed [SW-1:0] HS  = SW'(V / 2);
  localparam logic signed [SW-1:0] MS  = SW'(MARGIN);
  localparam logic signed [SW-1:0] HIS = SW'(V - 1 - MARGIN);
  localparam logic signed [SW-1:0] OMS = SW'(OMAX);
  localparam logic signed [SW-1:0] STS = SW'(MAX_STEP);

  typedef enum logic [1:0] {IDLE, CALC, PEND} state_t;

  state_t state_q, state_d;
  logic [MAP_W-1:0] tgt_x_q, tgt_x_d, tgt_y_q, tgt_y_d;
  logic [MAP_W-1:0] des_x_q, des_x_d, des_y_q, des_y_d;
  logic [MAP_W-1:0] off_x_q, off_x_d, off_y_q, off_y_d;
  logic [MAP_W-1:0] cx, cy, nx, ny;
  logic [ADDR_W-1:0] map_row_q, map_row_d;
  logic [ADDR_W-1:0] map_col_q, map_col_d;
  logic in_view_q, in_view_d;

  function automatic logic [MAP_W-1:0] clamp(
    input logic signed [SW-1:0] a
  );
    if (a[SW-1])      clamp = '0;
    else if (a > OMS) clamp = OMS[MAP_W-1:0];
    else              clamp = a[MAP_W-1:0];
  endfunction

  function automatic logic [MAP_W-1:0] calc_des(
    input logic [1:0]       m,
    input logic [MAP_W-1:0] t,
    input logic [MAP_W-1:0] o
  );
    logic signed [SW-1:0] ts, os, rel;
    ts  = {2'b00, t};
    os  = {2'b00, o};
    rel = ts - os;
    case (m)
      2'b00, 2'b01: calc_des = clamp(ts - HS);
      2'b10: begin
        if (rel < MS)       calc_des = clamp(ts - MS);
        else if (rel > HIS) calc_des = clamp(ts - HIS);
        else                calc_des = o;
      end
      default: calc_des = o;
    endcase
  endfunction

  function automatic logic [MAP_W-1:0] apply_off(
    input logic [1:0]       m,
    input logic [MAP_W-1:0] d,
    input logic [MAP_W-1:0] o
  );
    logic signed [SW-1:0] diff;
    diff = $signed({2'b00, d}) - $signed({2'b00, o});
    case (m)
      2'b00, 2'b10: apply_off = d;
      2'b01: begin
        if (diff > STS)       apply_off = o + MAP_W'(MAX_STEP);
        else if (diff < -STS) apply_off = o - MAP_W'(MAX_STEP);
        else                  apply_off = d;
      end
      default: apply_off = o;
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    tgt_x_d = tgt_x_q;
    tgt_y_d = tgt_y_q;
    des_x_d = des_x_q;
    des_y_d = des_y_q;
    off_x_d = off_x_q;
    off_y_d = off_y_q;
    cx = calc_des(scroll_mode, tgt_x_q, off_x_q);
    cy = calc_des(scroll_mode, tgt_y_q, off_y_q);
    nx = apply_off(scroll_mode, des_x_q, off_x_q);
    ny = apply_off(scroll_mode, des_y_q, off_y_q);
    if (loc_valid) begin
      tgt_x_d = LocX;
      tgt_y_d = LocY;
    end
    unique case (state_q)
      IDLE: if (loc_valid) state_d = CALC;
      CALC: begin
        des_x_d = cx;
        des_y_d = cy;
        if (loc_valid)                          state_d = CALC;
        else if (cx == off_x_q && cy == off_y_q) state_d = IDLE;
        else                                    state_d = PEND;
      end
      PEND: begin
        // the frame update always uses the des already held
        if (frame_sync) begin
          off_x_d = nx;
          off_y_d = ny;
        end
        if (loc_valid) state_d = CALC;
        else if (frame_sync &&
                 (scroll_mode == 2'b11 ||
                  (nx == des_x_q && ny == des_y_q)))
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_view_d = ~|vid_row[ADDR_W-1:VIEW_W]
              & ~|vid_col[ADDR_W-1:VIEW_W];
    map_row_d = '0;
    map_col_d = '0;
    if (in_view_d) begin
      map_row_d = vid_row + {{(ADDR_W-MAP_W){1'b0}}, off_y_q};
      map_col_d = vid_col + {{(ADDR_W-MAP_W){1'b0}}, off_x_q};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      tgt_x_q   <= '0;
      tgt_y_q   <= '0;
      des_x_q   <= '0;
      des_y_q   <= '0;
      off_x_q   <= '0;
      off_y_q   <= '0;
      map_row_q <= '0;
      map_col_q <= '0;
      in_view_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      tgt_x_q   <= tgt_x_d;
      tgt_y_q   <= tgt_y_d;
      des_x_q   <= des_x_d;
      des_y_q   <= des_y_d;
      off_x_q   <= off_x_d;
      off_y_q   <= off_y_d;
      map_row_q <= map_row_d;
      map_col_q <= map_col_d;
      in_view_q <= in_view_d;
    end
  end

  assign map_row = map_row_q;
  assign map_col = map_col_q;
  assign in_view = in_view_q;
  assign off_x   = off_x_q;
  assign off_y   = off_y_q;
  assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_bot_viewport_scroller.sv
// Directed bench for bot_viewport_scroller: scroll modes, frame timing,
// video mapping and reset behaviour at default parameters.
module tb_bot_viewport_scroller;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  LocX, LocY;
  logic        loc_valid, frame_sync;
  logic [1:0]  scroll_mode;
  logic [10:0] vid_row, vid_col;
  logic [10:0] map_row, map_col;
  logic        in_view;
  logic [7:0]  off_x, off_y;
  logic        busy;

  int vectors = 0;
  int errs    = 0;

  bot_viewport_scroller dut (
    .clk(clk), .reset(reset),
    .LocX(LocX), .LocY(LocY),
    .loc_valid(loc_valid), .frame_sync(frame_sync),
    .scroll_mode(scroll_mode),
    .vid_row(vid_row), .vid_col(vid_col),
    .map_row(map_row), .map_col(map_col),
    .in_view(in_view),
    .off_x(off_x), .off_y(off_y),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic move(input int x, input int y);
    LocX = 8'(x);
    LocY = 8'(y);
    loc_valid = 1'b1;
    tick();
    loc_valid = 1'b0;
    tick();
  endtask

  task automatic frame();
    frame_sync = 1'b1;
    tick();
    frame_sync = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    LocX = '0; LocY = '0;
    loc_valid = 1'b0; frame_sync = 1'b0;
    scroll_mode = 2'b00;
    vid_row = 11'd5; vid_col = 11'd7;
    tick(); tick();
    chk("rst_map_row", map_row, 0);
    chk("rst_map_col", map_col, 0);
    chk("rst_in_view", in_view, 0);
    chk("rst_off_x", off_x, 0);
    chk("rst_off_y", off_y, 0);
    chk("rst_busy", busy, 0);

    reset = 1'b1;
    tick();
    chk("pass_row", map_row, 5);
    chk("pass_col", map_col, 7);
    chk("pass_in_view", in_view, 1);

    // centred
    move(100, 10);
    chk("c_busy_pend", busy, 1);
    chk("c_off_x_wait", off_x, 0);
    frame();
    chk("c_off_x", off_x, 68);
    chk("c_off_y", off_y, 0);
    chk("c_busy_done", busy, 0);
    vid_row = 11'd0; vid_col = 11'd3;
    tick();
    chk("c_map_col", map_col, 71);
    move(250, 10); frame();
    chk("c_clamp_hi", off_x, 192);
    move(20, 10); frame();
    chk("c_clamp_lo", off_x, 0);

    // smooth
    scroll_mode = 2'b01;
    move(100, 10);
    for (int k = 1; k <= 17; k++) begin
      frame();
      chk($sformatf("s_off_x_%0d", k), off_x, (4 * k > 68) ? 68 : 4 * k);
      if (k == 16) chk("s_busy_16", busy, 1);
    end
    chk("s_busy_done", busy, 0);
    chk("s_off_y", off_y, 0);

    // dead-zone
    scroll_mode = 2'b10;
    move(100, 10);
    chk("d_inside_busy", busy, 0);
    chk("d_inside_off", off_x, 68);
    move(130, 10);
    chk("d_edge_busy", busy, 1);
    frame();
    chk("d_edge_off", off_x, 75);
    chk("d_edge_done", busy, 0);

    // simultaneous loc_valid + frame_sync in PEND
    scroll_mode = 2'b00;
    move(100, 10);
    chk("sim_pend", busy, 1);
    LocX = 8'd150; loc_valid = 1'b1; frame_sync = 1'b1;
    tick();
    loc_valid = 1'b0; frame_sync = 1'b0;
    chk("sim_old_des", off_x, 68);
    chk("sim_calc", busy, 1);
    tick();
    chk("sim_hold", off_x, 68);
    chk("sim_pend2", busy, 1);
    frame();
    chk("sim_new_des", off_x, 118);
    chk("sim_done", busy, 0);

    // freeze while a scroll is pending
    move(200, 10);
    chk("f_pend", busy, 1);
    scroll_mode = 2'b11;
    for (int k = 0; k < 3; k++) begin
      frame();
      chk($sformatf("f_off_x_%0d", k), off_x, 118);
    end
    chk("f_busy", busy, 0);

    // video boundaries
    vid_row = 11'd0; vid_col = 11'd64;
    tick();
    chk("ov_in_view", in_view, 0);
    chk("ov_map_col", map_col, 0);
    vid_row = 11'd63; vid_col = 11'd63;
    tick();
    chk("edge_in_view", in_view, 1);
    chk("edge_map_row", map_row, 63);
    chk("edge_map_col", map_col, 181);
    vid_row = 11'd64; vid_col = 11'd0;
    tick();
    chk("ovr_in_view", in_view, 0);
    chk("ovr_map_row", map_row, 0);

    // reset mid-scroll
    scroll_mode = 2'b00;
    move(20, 10);
    chk("r_busy", busy, 1);
    #2;
    reset = 1'b0;
    #1;
    chk("r_off_x", off_x, 0);
    chk("r_busy_clr", busy, 0);
    chk("r_map_row", map_row, 0);
    chk("r_in_view", in_view, 0);
    tick();
    reset = 1'b1;
    frame();
    chk("r_no_resume", off_x, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
